// File: rtl/sha256_msched_ctrl.sv
// SHA-256 message schedule controller.
// Loads a 16-word message block, then streams the 64 schedule words W[0..63].
// The schedule is expanded in place in a 16-entry circular buffer.
// Ports:
//   g_clk, g_reset  - clock and asynchronous active-high reset
//   flush           - synchronous abort back to LOAD
//   in_valid/in_ready/in_data               - message word input (W[0..15])
//   out_valid/out_ready/out_data/out_idx    - schedule word output and its index t
//   busy            - high while loading or streaming
//   done            - one-cycle pulse after W[63] is accepted
module sha256_msched_ctrl (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_idx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LAST_T = 63;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   t_q, t_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WORD_W-1:0]  out_data_q, out_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WORD_W-1:0]  wbuf_q [DEPTH];
    logic [WORD_W-1:0]  wbuf_d [DEPTH];

    logic [IDX_W-1:0]   sel_idx;
    logic [CNT_W-1:0]   sel_lo;
    logic [WORD_W-1:0]  next_word;
    logic               in_hs;
    logic               out_hs;

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    assign in_hs  = in_valid & in_ready_q;
    assign out_hs = out_valid_q & out_ready;

    // Index of the word presented after the next transition: t+1 in RUN, 0 when entering RUN.
    // W[t+1] never reads the slot being written at t, so the old buffer contents suffice.
    assign sel_idx = (state_q == S_RUN) ? (t_q + IDX_W'(1)) : '0;
    assign sel_lo  = sel_idx[CNT_W-1:0];

    // Schedule word for sel_idx; ring offsets -2, -7, -15, -16 wrap modulo 16.
    always_comb begin
        next_word = '0;
        if (sel_idx < IDX_W'(DEPTH)) begin
            next_word = wbuf_q[sel_lo];
        end else begin
            next_word = sig1(wbuf_q[sel_lo - CNT_W'(2)]) + wbuf_q[sel_lo - CNT_W'(7)]
                      + sig0(wbuf_q[sel_lo - CNT_W'(15)]) + wbuf_q[sel_lo];
        end
    end

    // Next-state, buffer update and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        t_d        = t_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        wbuf_d     = wbuf_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_LOAD;
                cnt_d   = '0;
                t_d     = '0;
            end
            S_LOAD: begin
                if (in_hs) begin
                    wbuf_d[cnt_q] = in_data;
                    cnt_d         = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_d    = S_RUN;
                        t_d        = '0;
                        out_data_d = next_word;
                    end
                end
            end
            S_RUN: begin
                if (out_hs) begin
                    if (t_q >= IDX_W'(DEPTH)) begin
                        wbuf_d[t_q[CNT_W-1:0]] = out_data_q;
                    end
                    if (t_q == IDX_W'(LAST_T)) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                        t_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        t_d        = t_q + IDX_W'(1);
                        out_data_d = next_word;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over any handshake in the same cycle.
        if (flush) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            t_d     = '0;
            done_d  = 1'b0;
        end

        if (state_d != S_RUN) begin
            out_data_d = '0;
        end

        in_ready_d  = (state_d == S_LOAD);
        out_valid_d = (state_d == S_RUN);
        busy_d      = (state_d != S_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            t_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_q         <= t_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Word buffer needs no reset: every slot is loaded before it is read.
    always_ff @(posedge g_clk) begin
        wbuf_q <= wbuf_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = t_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sha256_msched_ctrl.sv
// Directed testbench for sha256_msched_ctrl with an independent schedule model.
module tb_sha256_msched_ctrl;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [5:0]  out_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [31:0] blk   [16];
    logic [31:0] ref_w [64];
    logic [31:0] got_w [64];

    sha256_msched_ctrl dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 g_clk = ~g_clk;

    always @(posedge g_clk) cyc <= cyc + 1;

    always @(negedge g_clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic compute_ref();
        for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            ref_w[t] = ms1(ref_w[t-2]) + ref_w[t-7] + ms0(ref_w[t-15]) + ref_w[t-16];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            int   guard;
            logic acc;
            guard    = 0;
            acc      = 1'b0;
            in_valid = 1'b1;
            in_data  = blk[i];
            while (!acc && guard < 50) begin
                acc = in_ready;
                tick();
                guard++;
            end
            chk("load_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"},  out_data,       32'd0);
        chk({tag, "_out_idx"},   32'(out_idx),   32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Consume outputs; flush_at < 64 aborts with a simultaneous handshake at that index.
    task automatic drain(input bit stall, input int flush_at);
        int          k;
        int          guard;
        bit          flushed;
        logic        v;
        logic        r;
        logic [31:0] d;
        logic [5:0]  ix;
        k       = 0;
        guard   = 0;
        flushed = 1'b0;
        while (k < 64 && guard < 2000) begin
            r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == flush_at && out_valid === 1'b1) begin
                flush = 1'b1;
                r     = 1'b1;
            end
            out_ready = r;
            v  = out_valid;
            d  = out_data;
            ix = out_idx;
            tick();
            guard++;
            if (flush) begin
                flush   = 1'b0;
                flushed = 1'b1;
                break;
            end
            if (v && r) begin
                got_w[k] = d;
                chk("out_data", d, ref_w[k]);
                chk("out_idx", 32'(ix), 32'(k));
                k++;
            end else if (v) begin
                chk("stall_data", out_data, d);
                chk("stall_idx", 32'(out_idx), 32'(ix));
            end
        end
        out_ready = 1'b0;
        if (flushed) begin
            chk("flush_done",      32'(done),      32'd0);
            chk("flush_in_ready",  32'(in_ready),  32'd1);
            chk("flush_out_valid", 32'(out_valid), 32'd0);
            chk("flush_out_idx",   32'(out_idx),   32'd0);
        end else begin
            chk("drain_count",     32'(k),         32'd64);
            chk("done_pulse",      32'(done),      32'd1);
            chk("done_out_valid",  32'(out_valid), 32'd0);
            chk("done_in_ready",   32'(in_ready),  32'd1);
            chk("done_out_data",   out_data,       32'd0);
        end
    endtask

    initial begin
        int start_cyc;
        int dc;

        // Reset values
        tick();
        tick();
        check_reset_outputs("reset");

        // IDLE for one cycle, then LOAD
        g_reset = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_busy",     32'(busy),     32'd0);
        tick();
        chk("load_in_ready", 32'(in_ready), 32'd1);
        chk("load_busy",     32'(busy),     32'd1);

        // "abc" block
        set_abc();
        compute_ref();
        dc = done_cnt;
        load_words(16);
        chk("run_out_valid", 32'(out_valid), 32'd1);
        chk("run_in_ready",  32'(in_ready),  32'd0);
        chk("run_first_idx", 32'(out_idx),   32'd0);
        drain(1'b0, 64);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("abc_w0",  got_w[0],  32'h61626380);
        chk("abc_w15", got_w[15], 32'h00000018);
        chk("abc_w16", got_w[16], 32'h61626380);
        chk("abc_w17", got_w[17], 32'h000F0000);
        chk("abc_done_count", 32'(done_cnt - dc), 32'd1);

        // All-zero block, latency from first in_valid to done
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        compute_ref();
        start_cyc = cyc;
        load_words(16);
        drain(1'b0, 64);
        chk("zero_latency", 32'(cyc - start_cyc), 32'd80);
        tick();

        // abc again with random stalls
        set_abc();
        compute_ref();
        dc = done_cnt;
        load_words(16);
        drain(1'b1, 64);
        tick();
        chk("stall_done_count", 32'(done_cnt - dc), 32'd1);

        // Flush at t=30 with handshake, then a fresh block
        dc = done_cnt;
        load_words(16);
        drain(1'b0, 30);
        tick();
        chk("flush_no_done", 32'(done_cnt - dc), 32'd0);
        set_rand();
        compute_ref();
        load_words(16);
        drain(1'b0, 64);
        tick();

        // Reset pulse after 7 loaded words
        set_rand();
        compute_ref();
        load_words(7);
        dc = done_cnt;
        #2;
        g_reset = 1'b1;
        #1;
        check_reset_outputs("midload_reset");
        tick();
        g_reset = 1'b0;
        chk("post_reset_idle", 32'(in_ready), 32'd0);
        tick();
        chk("post_reset_load", 32'(in_ready), 32'd1);
        chk("reset_no_done", 32'(done_cnt - dc), 32'd0);
        load_words(16);
        drain(1'b0, 64);

        // Two back-to-back blocks
        set_rand();
        compute_ref();
        load_words(16);
        drain(1'b0, 64);
        set_rand();
        compute_ref();
        load_words(16);
        drain(1'b0, 64);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
